// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - address map, register offsets and state encoding for irq_ctrl
package irq_ctrl_pkg;

  localparam logic [15:0] DEVIRQADDR_BEGIN = 16'h7F20;
  localparam logic [15:0] DEVIRQADDR_END   = 16'h7F3F;
  localparam int          NIRQ_DEFAULT     = 6;

  localparam logic [4:0] IRQ_CTRL  = 5'h00;
  localparam logic [4:0] IRQ_MASK  = 5'h04;
  localparam logic [4:0] IRQ_MODE  = 5'h08;
  localparam logic [4:0] IRQ_PEND  = 5'h0C;
  localparam logic [4:0] IRQ_ISR   = 5'h10;
  localparam logic [4:0] IRQ_CLAIM = 5'h14;
  localparam logic [4:0] IRQ_EOI   = 5'h18;

  typedef enum logic {
    IRQ_IDLE = 1'b0,
    IRQ_REQ  = 1'b1
  } irq_state_e;

  // ids 6 and 7 map to no line, so ACK/EOI with them touch nothing
  function automatic logic [5:0] onehot6(input logic [2:0] id);
    return 6'b000001 << id;
  endfunction

endpackage

// File: rtl/irq_ctrl_prio_enc6.sv
// rtl/irq_ctrl_prio_enc6.sv - lowest-set-bit encoder, bit 0 is highest priority
module prio_enc6 (
  input  logic [5:0] req_i,
  output logic       valid_o,
  output logic [2:0] id_o
);

  always_comb begin
    valid_o = 1'b0;
    id_o    = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        id_o    = 3'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - maskable, prioritised, nesting interrupt controller on the 16-bit device bus
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter logic [15:0] BASE = DEVIRQADDR_BEGIN,
  parameter int          NIRQ = NIRQ_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     addr,
  input  logic            we,
  input  logic [31:0]     wd,
  output logic [31:0]     RD,
  input  logic [NIRQ-1:0] irq_in,
  output logic [NIRQ-1:0] HWInt
);

  logic [NIRQ-1:0] irq_q, pend_q, pend_d, mask_q, mode_q, isr_q, isr_d;
  logic [NIRQ-1:0] hwint_q, hwint_d, rise, edge_clr, floor_mask, elig;
  logic            ge_q, err_q, err_d;
  logic [2:0]      winner_q, winner_d, win_id, floor_id;
  logic            win_valid, floor_valid;
  irq_state_e      state_q, state_d;

  logic [15:0] offset;
  logic [4:0]  reg_select;
  logic        hit, wr_ctrl, wr_mask, wr_mode, wr_pend, wr_claim, wr_eoi;
  logic        ack_ok, ack_err;
  logic        unused_wd;

  assign offset     = addr - BASE;
  assign hit        = (offset[15:5] == 11'd0);
  assign reg_select = offset[4:0];
  assign unused_wd  = ^wd[31:6];

  assign wr_ctrl  = we && hit && (reg_select == IRQ_CTRL);
  assign wr_mask  = we && hit && (reg_select == IRQ_MASK);
  assign wr_mode  = we && hit && (reg_select == IRQ_MODE);
  assign wr_pend  = we && hit && (reg_select == IRQ_PEND);
  assign wr_claim = we && hit && (reg_select == IRQ_CLAIM);
  assign wr_eoi   = we && hit && (reg_select == IRQ_EOI);

  assign ack_ok  = wr_claim && (state_q == IRQ_REQ) && (wd[2:0] == winner_q);
  assign ack_err = wr_claim && !ack_ok;

  // Edge bits: set beats clear; level bits simply follow the line
  assign rise     = irq_in & ~irq_q;
  assign edge_clr = (wr_pend ? wd[NIRQ-1:0] : '0) | (ack_ok ? onehot6(winner_q) : '0);
  assign pend_d   = (mode_q & ((pend_q & ~edge_clr) | rise)) | (~mode_q & irq_in);

  always_comb begin
    isr_d = isr_q;
    if (ack_ok) isr_d = isr_d | onehot6(winner_q);
    if (wr_eoi) isr_d = isr_d & ~onehot6(wd[2:0]);
  end

  assign err_d = (err_q && !(wr_ctrl && wd[1])) || ack_err;

  prio_enc6 u_floor (.req_i(isr_q), .valid_o(floor_valid), .id_o(floor_id));

  assign floor_mask = floor_valid ? (onehot6(floor_id) - 6'd1) : '1;
  assign elig       = pend_q & mask_q & {NIRQ{ge_q}} & floor_mask;

  prio_enc6 u_winner (.req_i(elig), .valid_o(win_valid), .id_o(win_id));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IRQ_IDLE;
      winner_q <= 3'd0;
      hwint_q  <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      hwint_q  <= hwint_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    if (state_q == IRQ_IDLE) begin
      if (win_valid) begin
        state_d  = IRQ_REQ;
        winner_d = win_id;
      end
    end else if (ack_ok || !win_valid) begin
      state_d = IRQ_IDLE;
    end else begin
      winner_d = win_id;
    end
  end

  always_comb begin
    hwint_d = (state_d == IRQ_REQ) ? onehot6(winner_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q  <= '0;
      pend_q <= '0;
      isr_q  <= '0;
      mask_q <= '0;
      mode_q <= '0;
      ge_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      irq_q  <= irq_in;
      pend_q <= pend_d;
      isr_q  <= isr_d;
      err_q  <= err_d;
      if (wr_mask) mask_q <= wd[NIRQ-1:0];
      if (wr_mode) mode_q <= wd[NIRQ-1:0];
      if (wr_ctrl) ge_q   <= wd[0];
    end
  end

  always_comb begin
    RD = 32'd0;
    if (hit) begin
      case (reg_select)
        IRQ_CTRL:  RD = {30'd0, err_q, ge_q};
        IRQ_MASK:  RD = {26'd0, mask_q};
        IRQ_MODE:  RD = {26'd0, mode_q};
        IRQ_PEND:  RD = {26'd0, pend_q};
        IRQ_ISR:   RD = {26'd0, isr_q};
        IRQ_CLAIM: RD = {(state_q == IRQ_REQ), 28'd0, winner_q};
        default:   RD = 32'd0;
      endcase
    end
  end

  assign HWInt = hwint_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed scenario bench for irq_ctrl
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr = DEVIRQADDR_BEGIN;
  logic        we = 1'b0;
  logic [31:0] wd = 32'd0;
  logic [31:0] RD;
  logic [5:0]  irq_in = 6'd0;
  logic [5:0]  HWInt;

  int tests = 0;
  int fails = 0;

  irq_ctrl dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .wd(wd),
    .RD(RD), .irq_in(irq_in), .HWInt(HWInt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [4:0] off, input logic [31:0] d);
    @(negedge clk);
    addr = DEVIRQADDR_BEGIN + 16'(off);
    wd   = d;
    we   = 1'b1;
    @(negedge clk);
    we   = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] off, output logic [31:0] d);
    addr = DEVIRQADDR_BEGIN + 16'(off);
    #1 d = RD;
  endtask

  task automatic pulse(input int i);
    @(negedge clk);
    irq_in[i] = 1'b1;
    @(negedge clk);
    irq_in[i] = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    tick();
    tick();
    reset = 1'b0;
    tests++;
    if (HWInt !== 6'd0) begin fails++; $display("FAIL reset_hwint got %b want %b", HWInt, 6'd0); end
    bus_read(IRQ_CTRL, d);
    tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL reset_ctrl got %h want %h", d, 32'd0); end
    bus_read(IRQ_CLAIM, d);
    tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL reset_claim got %h want %h", d, 32'd0); end
  endtask

  task automatic test_edge_ack();
    logic [31:0] d;
    bus_write(IRQ_CTRL, 32'h1);
    bus_write(IRQ_MASK, 32'h3F);
    bus_write(IRQ_MODE, 32'h3F);
    pulse(2);
    bus_read(IRQ_PEND, d);
    tests++;
    if (d !== 32'h04) begin fails++; $display("FAIL edge_pend got %h want %h", d, 32'h04); end
    tests++;
    if (HWInt !== 6'd0) begin fails++; $display("FAIL edge_hwint_early got %b want %b", HWInt, 6'd0); end
    tick();
    tests++;
    if (HWInt !== 6'b000100) begin fails++; $display("FAIL edge_hwint got %b want %b", HWInt, 6'b000100); end
    bus_read(IRQ_CLAIM, d);
    tests++;
    if (d !== 32'h80000002) begin fails++; $display("FAIL edge_claim got %h want %h", d, 32'h80000002); end
    bus_write(IRQ_CLAIM, 32'd2);
    bus_read(IRQ_ISR, d);
    tests++;
    if (d !== 32'h04) begin fails++; $display("FAIL ack_isr got %h want %h", d, 32'h04); end
    bus_read(IRQ_PEND, d);
    tests++;
    if (d !== 32'h00) begin fails++; $display("FAIL ack_pend got %h want %h", d, 32'h00); end
    tests++;
    if (HWInt !== 6'd0) begin fails++; $display("FAIL ack_hwint got %b want %b", HWInt, 6'd0); end
  endtask

  task automatic test_nesting();
    logic [31:0] d;
    pulse(4);
    bus_read(IRQ_PEND, d);
    tests++;
    if (d !== 32'h10) begin fails++; $display("FAIL nest_pend got %h want %h", d, 32'h10); end
    tick();
    tests++;
    if (HWInt !== 6'd0) begin fails++; $display("FAIL nest_blocked got %b want %b", HWInt, 6'd0); end
    pulse(0);
    tick();
    tests++;
    if (HWInt !== 6'b000001) begin fails++; $display("FAIL nest_preempt got %b want %b", HWInt, 6'b000001); end
    bus_write(IRQ_CLAIM, 32'd0);
    bus_read(IRQ_ISR, d);
    tests++;
    if (d !== 32'h05) begin fails++; $display("FAIL nest_isr got %h want %h", d, 32'h05); end
    bus_write(IRQ_EOI, 32'd0);
    tick();
    tests++;
    if (HWInt !== 6'd0) begin fails++; $display("FAIL nest_still_blocked got %b want %b", HWInt, 6'd0); end
    bus_write(IRQ_EOI, 32'd2);
    tick();
    tests++;
    if (HWInt !== 6'b010000) begin fails++; $display("FAIL nest_release got %b want %b", HWInt, 6'b010000); end
    bus_write(IRQ_CLAIM, 32'd4);
    bus_write(IRQ_EOI, 32'd4);
    bus_read(IRQ_EOI, d);
    tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL eoi_reads_zero got %h want %h", d, 32'd0); end
  endtask

  task automatic test_level();
    logic [31:0] d;
    irq_in[1] = 1'b1;
    bus_write(IRQ_MODE, 32'h0);
    tick();
    tests++;
    if (HWInt !== 6'b000010) begin fails++; $display("FAIL level_req got %b want %b", HWInt, 6'b000010); end
    bus_write(IRQ_CLAIM, 32'd1);
    tick();
    tests++;
    if (HWInt !== 6'd0) begin fails++; $display("FAIL level_in_service got %b want %b", HWInt, 6'd0); end
    bus_write(IRQ_EOI, 32'd1);
    tests++;
    if (HWInt !== 6'd0) begin fails++; $display("FAIL level_eoi_edge got %b want %b", HWInt, 6'd0); end
    tick();
    tests++;
    if (HWInt !== 6'b000010) begin fails++; $display("FAIL level_retrigger got %b want %b", HWInt, 6'b000010); end
    bus_write(IRQ_CLAIM, 32'd1);
    irq_in[1] = 1'b0;
    tick();
    bus_write(IRQ_EOI, 32'd1);
    tick();
    tick();
    tests++;
    if (HWInt !== 6'd0) begin fails++; $display("FAIL level_dropped got %b want %b", HWInt, 6'd0); end
    bus_read(IRQ_PEND, d);
    tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL level_pend_clear got %h want %h", d, 32'd0); end
  endtask

  task automatic test_mask_enable();
    logic [31:0] d;
    bus_write(IRQ_MODE, 32'h3F);
    bus_write(IRQ_MASK, 32'h0);
    pulse(3);
    bus_read(IRQ_PEND, d);
    tests++;
    if (d !== 32'h08) begin fails++; $display("FAIL mask_pend got %h want %h", d, 32'h08); end
    tick();
    tests++;
    if (HWInt !== 6'd0) begin fails++; $display("FAIL mask_blocks got %b want %b", HWInt, 6'd0); end
    bus_write(IRQ_MASK, 32'h08);
    tick();
    tests++;
    if (HWInt !== 6'b001000) begin fails++; $display("FAIL mask_enable got %b want %b", HWInt, 6'b001000); end
    bus_write(IRQ_CTRL, 32'h0);
    tick();
    tests++;
    if (HWInt !== 6'd0) begin fails++; $display("FAIL ge_off got %b want %b", HWInt, 6'd0); end
  endtask

  task automatic test_protocol_error();
    logic [31:0] d;
    bus_write(IRQ_CTRL, 32'h1);
    tick();
    bus_read(IRQ_CLAIM, d);
    tests++;
    if (d !== 32'h80000003) begin fails++; $display("FAIL err_claim got %h want %h", d, 32'h80000003); end
    bus_write(IRQ_CLAIM, 32'd5);
    bus_read(IRQ_CTRL, d);
    tests++;
    if (d !== 32'h3) begin fails++; $display("FAIL err_set got %h want %h", d, 32'h3); end
    bus_read(IRQ_ISR, d);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL err_isr got %h want %h", d, 32'h0); end
    tests++;
    if (HWInt !== 6'b001000) begin fails++; $display("FAIL err_hwint got %b want %b", HWInt, 6'b001000); end
    bus_write(IRQ_CTRL, 32'h3);
    bus_read(IRQ_CTRL, d);
    tests++;
    if (d !== 32'h1) begin fails++; $display("FAIL err_clear got %h want %h", d, 32'h1); end
    bus_read(5'h1C, d);
    tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL unmapped_read got %h want %h", d, 32'd0); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bus_write(IRQ_MASK, 32'h3F);
    bus_write(IRQ_PEND, 32'h3F);
    bus_write(IRQ_EOI, 32'd3);
    pulse(2);
    tick();
    bus_write(IRQ_CLAIM, 32'd2);
    pulse(1);
    tick();
    bus_read(IRQ_ISR, d);
    tests++;
    if (d !== 32'h04 || HWInt !== 6'b000010) begin
      fails++; $display("FAIL pre_reset isr %h hwint %b want 04 000010", d, HWInt);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if (HWInt !== 6'd0) begin fails++; $display("FAIL rst_hwint got %b want %b", HWInt, 6'd0); end
    for (int off = 0; off <= 24; off += 4) begin
      bus_read(5'(off), d);
      tests++;
      if (d !== 32'd0) begin fails++; $display("FAIL rst_reg_%0h got %h want %h", off, d, 32'd0); end
    end
  endtask

  initial begin
    test_reset();
    test_edge_ack();
    test_nesting();
    test_level();
    test_mask_enable();
    test_protocol_error();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
